// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-hole mole generator.
// Holds the round-controller state encoding and the level-to-hold-time rule.
package mole_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PICK,
        ST_SHOW,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [7:0]  SCORE_MAX = 8'd255;

    // Each difficulty level halves the show time, never dropping below one tick.
    function automatic int unsigned hold_ticks(input int unsigned base, input logic [1:0] lvl);
        int unsigned t;
        t = base >> lvl;
        return (t == 0) ? 1 : t;
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 16-bit Galois LFSR; reloads SEED on reset or if it ever locks up at zero.
module mole_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk1s,
    input  logic        clr,
    output logic [15:0] q
);
    import mole_pkg::*;

    always_ff @(posedge clk1s) begin
        if (clr || q == 16'h0) begin
            q <= SEED;
        end else begin
            q <= (q >> 1) ^ (q[0] ? LFSR_TAPS : 16'h0);
        end
    end

endmodule

// File: rtl/mole_seq_gen.sv
// Round controller for whack-a-hole: picks a hole per round (pattern or LFSR),
// shows it for a level-dependent number of ticks, judges key hits and keeps score.
module mole_seq_gen
    import mole_pkg::*;
#(
    parameter int NHOLE     = 4,
    parameter int PAT_LEN   = 10,
    parameter logic [PAT_LEN*$clog2(NHOLE)-1:0] PATTERN = 20'b10011000100010011001,
    parameter logic [15:0] SEED = 16'hACE1,
    parameter int BASE_HOLD = 8,
    parameter int GAP_TICKS = 1,
    parameter int ROUNDS    = 20,
    localparam int SEQ_W    = $clog2(NHOLE)
) (
    input  logic             clk1s,
    input  logic             clr,
    input  logic             tick_en,
    input  logic             start,
    input  logic             mode,
    input  logic [1:0]       level,
    input  logic [NHOLE-1:0] hit,
    output logic [NHOLE-1:0] mole,
    output logic [SEQ_W-1:0] seq,
    output logic             hit_ok,
    output logic             miss,
    output logic [7:0]       score,
    output logic             done
);

    localparam int RND_W  = $clog2(ROUNDS + 1);
    localparam int PTR_W  = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
    localparam int HOLD_W = $clog2(BASE_HOLD + 1);
    localparam int GAP_W  = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

    state_t             state, state_n;
    logic               mode_r, mode_n;
    logic [PTR_W-1:0]   ptr, ptr_n;
    logic [HOLD_W-1:0]  hold, hold_n;
    logic [GAP_W-1:0]   gap, gap_n;
    logic [RND_W-1:0]   rnd, rnd_n;
    logic [NHOLE-1:0]   mole_n;
    logic [SEQ_W-1:0]   seq_n, idx;
    logic [7:0]         score_n;
    logic               hit_ok_n, miss_n, done_n;
    logic [15:0]        lfsr_q;
    logic               unused_lfsr;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == SCORE_MAX) ? SCORE_MAX : v + 8'd1;
    endfunction

    mole_lfsr #(.SEED(SEED)) u_lfsr (
        .clk1s (clk1s),
        .clr   (clr),
        .q     (lfsr_q)
    );

    assign unused_lfsr = ^lfsr_q[15:SEQ_W];

    // In LFSR mode, bump the candidate so the same hole never shows twice in a row.
    always_comb begin
        idx = PATTERN[ptr*SEQ_W +: SEQ_W];
        if (mode_r) begin
            idx = lfsr_q[SEQ_W-1:0];
            if (idx == seq) idx = idx + SEQ_W'(1);
        end
    end

    always_comb begin
        state_n  = state;
        mode_n   = mode_r;
        ptr_n    = ptr;
        hold_n   = hold;
        gap_n    = gap;
        rnd_n    = rnd;
        mole_n   = mole;
        seq_n    = seq;
        score_n  = score;
        hit_ok_n = 1'b0;
        miss_n   = 1'b0;
        done_n   = done;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    mode_n  = mode;
                    score_n = '0;
                    rnd_n   = '0;
                    done_n  = 1'b0;
                    state_n = ST_PICK;
                end
            end
            ST_PICK: begin
                if (!mode_r) ptr_n = (ptr == PTR_W'(PAT_LEN - 1)) ? '0 : ptr + PTR_W'(1);
                seq_n   = idx;
                mole_n  = NHOLE'(1) << idx;
                hold_n  = HOLD_W'(hold_ticks(int'(BASE_HOLD), level));
                rnd_n   = rnd + RND_W'(1);
                state_n = ST_SHOW;
            end
            ST_SHOW: begin
                // A correct hit outranks a simultaneous timeout.
                if (hit == mole) begin
                    hit_ok_n = 1'b1;
                    score_n  = sat_inc(score);
                    mole_n   = '0;
                    gap_n    = GAP_W'(GAP_TICKS);
                    state_n  = ST_GAP;
                end else if (hit != '0) begin
                    miss_n = 1'b1;
                end else if (tick_en && hold == HOLD_W'(1)) begin
                    miss_n  = 1'b1;
                    mole_n  = '0;
                    gap_n   = GAP_W'(GAP_TICKS);
                    state_n = ST_GAP;
                end else if (tick_en) begin
                    hold_n = hold - HOLD_W'(1);
                end
            end
            ST_GAP: begin
                mole_n = '0;
                if (tick_en) begin
                    if (gap <= GAP_W'(1)) begin
                        if (rnd == RND_W'(ROUNDS)) begin
                            done_n  = 1'b1;
                            state_n = ST_DONE;
                        end else begin
                            state_n = ST_PICK;
                        end
                    end else begin
                        gap_n = gap - GAP_W'(1);
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk1s) begin
        if (clr) begin
            state  <= ST_IDLE;
            mode_r <= 1'b0;
            ptr    <= '0;
            hold   <= '0;
            gap    <= '0;
            rnd    <= '0;
            mole   <= '0;
            seq    <= '0;
            score  <= '0;
            hit_ok <= 1'b0;
            miss   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            mode_r <= mode_n;
            ptr    <= ptr_n;
            hold   <= hold_n;
            gap    <= gap_n;
            rnd    <= rnd_n;
            mole   <= mole_n;
            seq    <= seq_n;
            score  <= score_n;
            hit_ok <= hit_ok_n;
            miss   <= miss_n;
            done   <= done_n;
        end
    end

endmodule
